// File: rtl/aes_pio_loader_pkg.sv
// Shared types and constants for the AES PIO loader: opcodes, FSM states,
// bit positions inside the PIO command word and the status word.
package aes_pio_loader_pkg;

    localparam int TOG_BIT = 31;
    localparam int OP_LSB  = 24;
    localparam int OP_W    = 3;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_LOAD_KEY = 3'd1,
        OP_LOAD_MSG = 3'd2,
        OP_START    = 3'd3,
        OP_CLEAR    = 3'd4
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    localparam int STAT_KFULL    = 0;
    localparam int STAT_MFULL    = 1;
    localparam int STAT_BUSY     = 2;
    localparam int STAT_DONE     = 3;
    localparam int STAT_ERR      = 4;
    localparam int STAT_OVR      = 5;
    localparam int STAT_KCNT_LSB = 8;
    localparam int STAT_MCNT_LSB = 12;
    localparam int STAT_ACK      = 31;

endpackage

// File: rtl/aes_pio_loader_if.sv
// Bundle of the PIO command word, AES core start/done handshake and the
// assembled key/message/status outputs of the loader.
interface aes_pio_loader_if #(parameter int BLOCK_W = 128);
    logic [31:0]        pio_word;
    logic               start_ready;
    logic               done;
    logic [BLOCK_W-1:0] key_out;
    logic [BLOCK_W-1:0] msg_out;
    logic               start_valid;
    logic [31:0]        status;

    modport master (
        output pio_word, start_ready, done,
        input  key_out, msg_out, start_valid, status
    );

    modport slave (
        input  pio_word, start_ready, done,
        output key_out, msg_out, start_valid, status
    );
endinterface

// File: rtl/aes_shift_reg128.sv
// Shift-in block register with a saturating half-word count; clr wipes both.
module aes_shift_reg128 #(
    parameter int DATA_W  = 16,
    parameter int BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               shift_en,
    input  logic [DATA_W-1:0]  din,
    output logic [BLOCK_W-1:0] q,
    output logic [3:0]         cnt
);
    localparam logic [3:0] CNT_FULL = 4'(BLOCK_W / DATA_W);

    logic [BLOCK_W-1:0] q_reg;
    logic [3:0]         cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_reg   <= '0;
            cnt_reg <= '0;
        end else if (clr) begin
            q_reg   <= '0;
            cnt_reg <= '0;
        end else if (shift_en) begin
            q_reg <= {q_reg[BLOCK_W-DATA_W-1:0], din};
            // Count saturates but shifting continues, so the newest words win.
            if (cnt_reg != CNT_FULL)
                cnt_reg <= cnt_reg + 4'd1;
        end
    end

    assign q   = q_reg;
    assign cnt = cnt_reg;
endmodule

// File: rtl/aes_pio_loader.sv
// Toggle-handshake PIO command decoder that assembles AES key/message blocks
// and starts the core. Optional byte swap of payload: AES_PIO_LOADER_BYTESWAP_EN.
module aes_pio_loader
    import aes_pio_loader_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int BLOCK_W = 128
) (
    input  logic            clk,
    input  logic            reset_n,
    aes_pio_loader_if.slave bus
);
    localparam logic [3:0] CNT_FULL = 4'(BLOCK_W / DATA_W);

    state_e      state_reg;
    logic        prev_tog_reg;
    logic        start_valid_reg;
    logic        err_reg;
    logic        ovr_reg;
    logic        done_s_reg;

    logic              tog;
    logic              cmd;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data_raw;
    logic [DATA_W-1:0] data_in;
    logic [3:0]        kcnt;
    logic [3:0]        mcnt;
    logic              key_full;
    logic              msg_full;
    logic              clear_cmd;
    logic              idle_cmd;
    logic              unused_pio;
    logic [31:0]       status_word;

    assign tog       = bus.pio_word[TOG_BIT];
    assign cmd       = tog ^ prev_tog_reg;
    assign op        = bus.pio_word[OP_LSB +: OP_W];
    assign data_raw  = bus.pio_word[DATA_W-1:0];
    assign clear_cmd = cmd && (op == OP_CLEAR);
    assign idle_cmd  = cmd && (state_reg == ST_IDLE);
    assign key_full  = (kcnt == CNT_FULL);
    assign msg_full  = (mcnt == CNT_FULL);
    assign unused_pio = ^{bus.pio_word[TOG_BIT-1:OP_LSB+OP_W], bus.pio_word[OP_LSB-1:DATA_W]};

`ifdef AES_PIO_LOADER_BYTESWAP_EN
    // Reverse byte order so little-endian software strings land big-endian.
    for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_swap
        assign data_in[gi*8 +: 8] = data_raw[(DATA_W/8-1-gi)*8 +: 8];
    end
`else
    assign data_in = data_raw;
`endif

    aes_shift_reg128 #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W)) u_key (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clear_cmd),
        .shift_en (idle_cmd && (op == OP_LOAD_KEY)),
        .din      (data_in),
        .q        (bus.key_out),
        .cnt      (kcnt)
    );

    aes_shift_reg128 #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W)) u_msg (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clear_cmd),
        .shift_en (idle_cmd && (op == OP_LOAD_MSG)),
        .din      (data_in),
        .q        (bus.msg_out),
        .cnt      (mcnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            prev_tog_reg    <= 1'b0;
            start_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
            ovr_reg         <= 1'b0;
            done_s_reg      <= 1'b0;
        end else begin
            prev_tog_reg <= tog;
            // CLEAR overrides every state, including a coincident done pulse.
            if (clear_cmd) begin
                state_reg       <= ST_IDLE;
                start_valid_reg <= 1'b0;
                err_reg         <= 1'b0;
                ovr_reg         <= 1'b0;
                done_s_reg      <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (cmd) begin
                            case (op)
                                OP_NOP: ;
                                OP_LOAD_KEY, OP_LOAD_MSG: done_s_reg <= 1'b0;
                                OP_START: begin
                                    done_s_reg <= 1'b0;
                                    if (key_full && msg_full) begin
                                        state_reg       <= ST_ISSUE;
                                        start_valid_reg <= 1'b1;
                                    end else begin
                                        err_reg <= 1'b1;
                                    end
                                end
                                default: err_reg <= 1'b1;
                            endcase
                        end
                    end
                    ST_ISSUE: begin
                        if (cmd)
                            ovr_reg <= 1'b1;
                        if (bus.start_ready) begin
                            state_reg       <= ST_BUSY;
                            start_valid_reg <= 1'b0;
                        end
                    end
                    ST_BUSY: begin
                        if (cmd)
                            ovr_reg <= 1'b1;
                        if (bus.done) begin
                            state_reg  <= ST_IDLE;
                            done_s_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg       <= ST_IDLE;
                        start_valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        status_word                         = '0;
        status_word[STAT_KFULL]             = key_full;
        status_word[STAT_MFULL]             = msg_full;
        status_word[STAT_BUSY]              = (state_reg != ST_IDLE);
        status_word[STAT_DONE]              = done_s_reg;
        status_word[STAT_ERR]               = err_reg;
        status_word[STAT_OVR]               = ovr_reg;
        status_word[STAT_KCNT_LSB +: 4]     = kcnt;
        status_word[STAT_MCNT_LSB +: 4]     = mcnt;
        status_word[STAT_ACK]               = prev_tog_reg;
    end

    assign bus.status      = status_word;
    assign bus.start_valid = start_valid_reg;
endmodule

// File: tb/tb_aes_pio_loader.sv
// Randomized self-checking bench for aes_pio_loader against a queue-based model.
module tb_aes_pio_loader;
    import aes_pio_loader_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    aes_pio_loader_if bus ();

    aes_pio_loader dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic tog = 1'b0;

    // Model: blocks are the last (up to) 8 half-words loaded, oldest first.
    logic [15:0] m_kq[$];
    logic [15:0] m_mq[$];
    int          m_state;   // 0 idle, 1 waiting for accept, 2 core running
    bit          m_err, m_ovr, m_done, m_ack;

    bit          p_cmd, p_ready, p_done;
    logic [2:0]  p_op;
    logic [15:0] p_data;

    function automatic logic [15:0] model_data(input logic [15:0] d);
`ifdef AES_PIO_LOADER_BYTESWAP_EN
        return {d[7:0], d[15:8]};
`else
        return d;
`endif
    endfunction

    function automatic logic [127:0] pack(input logic [15:0] q[$]);
        logic [127:0] v = '0;
        for (int i = 0; i < q.size(); i++)
            v[16*(q.size()-1-i) +: 16] = q[i];
        return v;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s = '0;
        s[0]     = (m_kq.size() == 8);
        s[1]     = (m_mq.size() == 8);
        s[2]     = (m_state != 0);
        s[3]     = m_done;
        s[4]     = m_err;
        s[5]     = m_ovr;
        s[11:8]  = 4'(m_kq.size());
        s[15:12] = 4'(m_mq.size());
        s[31]    = m_ack;
        return s;
    endfunction

    task automatic model_reset();
        m_kq.delete(); m_mq.delete();
        m_state = 0; m_err = 0; m_ovr = 0; m_done = 0; m_ack = 0;
    endtask

    task automatic model_edge();
        if (p_cmd && p_op == OP_CLEAR) begin
            m_kq.delete(); m_mq.delete();
            m_state = 0; m_err = 0; m_ovr = 0; m_done = 0;
        end else if (m_state == 0) begin
            if (p_cmd) begin
                if (p_op == OP_LOAD_KEY) begin
                    m_kq.push_back(model_data(p_data));
                    if (m_kq.size() > 8) void'(m_kq.pop_front());
                    m_done = 0;
                end else if (p_op == OP_LOAD_MSG) begin
                    m_mq.push_back(model_data(p_data));
                    if (m_mq.size() > 8) void'(m_mq.pop_front());
                    m_done = 0;
                end else if (p_op == OP_START) begin
                    m_done = 0;
                    if (m_kq.size() == 8 && m_mq.size() == 8) m_state = 1;
                    else m_err = 1;
                end else if (p_op != OP_NOP) begin
                    m_err = 1;
                end
            end
        end else if (m_state == 1) begin
            if (p_cmd) m_ovr = 1;
            if (p_ready) m_state = 2;
        end else begin
            if (p_cmd) m_ovr = 1;
            if (p_done) begin m_state = 0; m_done = 1; end
        end
        m_ack = tog;
    endtask

    // Called just after a negedge; applies inputs for the next posedge.
    task automatic drive(input bit cmd, input logic [2:0] op, input logic [15:0] data,
                         input bit ready, input bit dn);
        if (cmd) tog = ~tog;
        bus.pio_word    = {tog, 4'($urandom_range(0, 15)), op, 8'($urandom_range(0, 255)), data};
        bus.start_ready = ready;
        bus.done        = dn;
        p_cmd = cmd; p_op = op; p_data = data; p_ready = ready; p_done = dn;
    endtask

    task automatic settle();
        @(negedge clk);
        model_edge();
    endtask

    task automatic step(input bit cmd, input logic [2:0] op, input logic [15:0] data,
                        input bit ready, input bit dn);
        drive(cmd, op, data, ready, dn);
        settle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tog = 1'b0;
        bus.pio_word = '0; bus.start_ready = 1'b0; bus.done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.status !== 32'h0) begin
            errors++; $display("FAIL reset_status: got %h expected %h", bus.status, 32'h0);
        end
        checks++;
        if (bus.key_out !== 128'h0 || bus.msg_out !== 128'h0 || bus.start_valid !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: key %h msg %h sv %b expected zeros",
                               bus.key_out, bus.msg_out, bus.start_valid);
        end
        reset_n = 1'b1;
        step(0, OP_NOP, 16'h0, 0, 0);
        checks++;
        if (bus.status !== exp_status()) begin
            errors++; $display("FAIL post_reset_status: got %h expected %h", bus.status, exp_status());
        end
        $display("test_reset done");
    endtask

    task automatic test_load_key();
        logic [127:0] want;
        for (int i = 1; i <= 8; i++) begin
            drive(1, OP_LOAD_KEY, 16'(i), 0, 0);
            #1;
            checks++;
            if (bus.status[31] !== m_ack) begin
                errors++; $display("FAIL ack_before_edge: got %b expected %b", bus.status[31], m_ack);
            end
            settle();
            checks++;
            if (bus.status !== exp_status()) begin
                errors++; $display("FAIL load_key_status: got %h expected %h", bus.status, exp_status());
            end
            $display("LOAD_KEY %0d key=%h status=%h", i, bus.key_out, bus.status);
        end
`ifdef AES_PIO_LOADER_BYTESWAP_EN
        want = 128'h0100_0200_0300_0400_0500_0600_0700_0800;
`else
        want = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
`endif
        checks++;
        if (bus.key_out !== want) begin
            errors++; $display("FAIL key_value: got %h expected %h", bus.key_out, want);
        end
        checks++;
        if (bus.status[11:8] !== 4'd8 || bus.status[0] !== 1'b1) begin
            errors++; $display("FAIL key_count: got %h expected kcnt 8 full 1", bus.status[11:0]);
        end
    endtask

    task automatic test_start_err();
        for (int i = 0; i < 3; i++) step(1, OP_LOAD_MSG, 16'($urandom), 0, 0);
        step(1, OP_START, 16'h0, 0, 0);
        checks++;
        if (bus.status[4] !== 1'b1 || bus.start_valid !== 1'b0 || bus.status !== exp_status()) begin
            errors++; $display("FAIL start_err: got status %h sv %b expected %h sv 0",
                               bus.status, bus.start_valid, exp_status());
        end
        for (int i = 0; i < 5; i++) step(1, OP_LOAD_MSG, 16'($urandom), 0, 0);
        step(1, OP_START, 16'h0, 0, 0);
        checks++;
        if (bus.start_valid !== 1'b1 || bus.msg_out !== pack(m_mq)) begin
            errors++; $display("FAIL start_ok: got sv %b msg %h expected sv 1 msg %h",
                               bus.start_valid, bus.msg_out, pack(m_mq));
        end
        $display("START msg=%h status=%h", bus.msg_out, bus.status);
    endtask

    task automatic test_handshake();
        for (int i = 0; i < 4; i++) begin
            step(0, OP_NOP, 16'($urandom), 0, 0);
            checks++;
            if (bus.start_valid !== 1'b1) begin
                errors++; $display("FAIL hold_valid: cycle %0d got %b expected 1", i, bus.start_valid);
            end
        end
        step(0, OP_NOP, 16'h0, 1, 0);
        checks++;
        if (bus.start_valid !== 1'b0 || bus.status !== exp_status()) begin
            errors++; $display("FAIL accept: got sv %b status %h expected sv 0 status %h",
                               bus.start_valid, bus.status, exp_status());
        end
        step(0, OP_NOP, 16'h0, 0, 1);
        checks++;
        if (bus.status[3] !== 1'b1 || bus.status[2] !== 1'b0 || bus.status !== exp_status()) begin
            errors++; $display("FAIL done: got status %h expected %h", bus.status, exp_status());
        end
        $display("handshake status=%h", bus.status);
    endtask

    task automatic test_overrun();
        logic [127:0] saved;
        step(1, OP_START, 16'h0, 0, 0);
        step(0, OP_NOP, 16'h0, 1, 0);
        saved = bus.key_out;
        step(1, OP_LOAD_KEY, 16'($urandom), 0, 0);
        checks++;
        if (bus.key_out !== saved || bus.status[5] !== 1'b1 || bus.status !== exp_status()) begin
            errors++; $display("FAIL overrun: got key %h status %h expected key %h status %h",
                               bus.key_out, bus.status, saved, exp_status());
        end
        step(1, OP_CLEAR, 16'h0, 0, 0);
        checks++;
        if (bus.status !== {tog, 31'h0} || bus.key_out !== 128'h0) begin
            errors++; $display("FAIL clear: got status %h key %h expected %h key 0",
                               bus.status, bus.key_out, {tog, 31'h0});
        end
        step(0, OP_NOP, 16'h0, 0, 1);
        checks++;
        if (bus.status !== exp_status()) begin
            errors++; $display("FAIL done_idle: got %h expected %h", bus.status, exp_status());
        end
        $display("overrun/clear status=%h", bus.status);
    endtask

    task automatic test_level_hold();
        logic [15:0] d = 16'($urandom);
        step(1, OP_LOAD_KEY, d, 0, 0);
        for (int i = 0; i < 10; i++) step(0, OP_LOAD_KEY, d, 0, 0);
        checks++;
        if (bus.status[11:8] !== 4'd1 || bus.key_out !== {112'h0, model_data(d)}) begin
            errors++; $display("FAIL level_hold: got kcnt %0d key %h expected 1 key %h",
                               bus.status[11:8], bus.key_out, {112'h0, model_data(d)});
        end
    endtask

    task automatic test_clear_vs_done();
        for (int i = 0; i < 8; i++) step(1, OP_LOAD_KEY, 16'($urandom), 0, 0);
        for (int i = 0; i < 8; i++) step(1, OP_LOAD_MSG, 16'($urandom), 0, 0);
        step(1, OP_START, 16'h0, 0, 0);
        step(0, OP_NOP, 16'h0, 1, 0);
        step(1, OP_CLEAR, 16'h0, 0, 1);
        checks++;
        if (bus.status !== exp_status() || bus.status[3] !== 1'b0) begin
            errors++; $display("FAIL clear_wins: got %h expected %h", bus.status, exp_status());
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) step(1, OP_LOAD_KEY, 16'($urandom), 0, 0);
        for (int i = 0; i < 8; i++) step(1, OP_LOAD_MSG, 16'($urandom), 0, 0);
        step(1, OP_START, 16'h0, 0, 0);
        checks++;
        if (bus.start_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_issue: got %b expected 1", bus.start_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.start_valid !== 1'b0 || bus.status !== 32'h0 || bus.key_out !== 128'h0) begin
            errors++; $display("FAIL async_reset: got sv %b status %h key %h expected zeros",
                               bus.start_valid, bus.status, bus.key_out);
        end
        tog = 1'b0;
        bus.pio_word = '0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        $display("async reset applied");
    endtask

    task automatic test_byteswap();
        logic [15:0] want;
`ifdef AES_PIO_LOADER_BYTESWAP_EN
        want = 16'h3412;
`else
        want = 16'h1234;
`endif
        step(1, OP_LOAD_KEY, 16'h1234, 0, 0);
        checks++;
        if (bus.key_out[15:0] !== want) begin
            errors++; $display("FAIL byteswap: got %h expected %h", bus.key_out[15:0], want);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        int r;
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 7)       op = OP_LOAD_KEY;
            else if (r < 14) op = OP_LOAD_MSG;
            else if (r < 17) op = OP_START;
            else if (r < 18) op = OP_CLEAR;
            else             op = 3'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, op, 16'($urandom),
                 $urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0);
            checks++;
            if (bus.status !== exp_status() || bus.key_out !== pack(m_kq) ||
                bus.msg_out !== pack(m_mq) || bus.start_valid !== (m_state == 1)) begin
                errors++;
                $display("FAIL random %0d: got status %h sv %b key %h msg %h expected status %h sv %b key %h msg %h",
                         n, bus.status, bus.start_valid, bus.key_out, bus.msg_out,
                         exp_status(), (m_state == 1), pack(m_kq), pack(m_mq));
            end
        end
        $display("random sequence done status=%h", bus.status);
    endtask

    initial begin
        test_reset();
        test_load_key();
        test_start_err();
        test_handshake();
        test_overrun();
        test_level_hold();
        test_clear_vs_done();
        test_async_reset();
        test_byteswap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
